// File: rtl/fnd_scan_decoder_if.sv
// Scanned 7-segment bus (digit select + segments) and the decoded frame it produces.
// The master drives the scan lines and clr_err; the slave returns the committed digits and flags.
interface fnd_scan_decoder_if;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;
  logic       clr_err;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dp_out;
  logic       frame_valid;
  logic       seg_err;
  logic       com_err;

  modport master (
    output fnd_com, fnd_data, clr_err,
    input  digit0, digit1, digit2, digit3, dp_out, frame_valid, seg_err, com_err
  );

  modport slave (
    input  fnd_com, fnd_data, clr_err,
    output digit0, digit1, digit2, digit3, dp_out, frame_valid, seg_err, com_err
  );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Recovers digit values from a multiplexed active-low 7-segment scan; capture STABLE_CYCLES+1 edges after an input change.
// No backpressure: the scan is sampled freely and a full 4-digit frame is committed atomically with a 1-cycle frame_valid.
module fnd_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  fnd_scan_decoder_if.slave bus
);

  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;
  state_t state;

  logic [3:0]      com_q;
  logic [3:0]      com_prev;
  logic [7:0]      data_q;
  logic [7:0]      data_prev;
  logic [7:0]      stab_cnt;
  logic [3:0]      mask;
  logic [3:0][3:0] shadow;
  logic [3:0]      shadow_dp;
  logic [3:0][3:0] digit_q;
  logic [3:0]      dp_q;
  logic            frame_valid_q;
  logic            seg_err_q;
  logic            com_err_q;

  logic            changed;
  logic            capture;
  logic            one_low;
  logic            multi_low;
  logic            seg_ok;
  logic            wr_ok;
  logic            seg_ev;
  logic            com_ev;
  logic [3:0]      seg_val;
  logic [3:0]      next_mask;
  logic [3:0][3:0] shadow_nxt;
  logic [3:0]      dp_nxt;

  // Counter value CNT_CAP on an unchanged edge means it reaches STABLE_CYCLES-1 on this edge.
  always_comb begin
    changed   = {com_q, data_q} != {com_prev, data_prev};
    capture   = (state == SETTLE) && !changed && (stab_cnt == CNT_CAP);
    one_low   = (com_q == 4'hE) || (com_q == 4'hD) || (com_q == 4'hB) || (com_q == 4'h7);
    multi_low = !one_low && (com_q != 4'hF);
  end

  always_comb begin
    seg_val = 4'h0;
    seg_ok  = 1'b1;
    case (data_q[6:0])
      7'h40:   seg_val = 4'h0;
      7'h79:   seg_val = 4'h1;
      7'h24:   seg_val = 4'h2;
      7'h30:   seg_val = 4'h3;
      7'h19:   seg_val = 4'h4;
      7'h12:   seg_val = 4'h5;
      7'h02:   seg_val = 4'h6;
      7'h78:   seg_val = 4'h7;
      7'h00:   seg_val = 4'h8;
      7'h10:   seg_val = 4'h9;
      7'h7F:   seg_val = 4'hF;
      default: seg_ok  = 1'b0;
    endcase
  end

  always_comb begin
    wr_ok     = capture && one_low && seg_ok;
    seg_ev    = capture && one_low && !seg_ok;
    com_ev    = capture && multi_low;
    next_mask = mask | ~com_q;
    for (int i = 0; i < 4; i++) begin
      shadow_nxt[i] = (wr_ok && !com_q[i]) ? seg_val : shadow[i];
      dp_nxt[i]     = (wr_ok && !com_q[i]) ? ~data_q[7] : shadow_dp[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      com_q         <= 4'hF;
      data_q        <= 8'hFF;
      com_prev      <= 4'hF;
      data_prev     <= 8'hFF;
      stab_cnt      <= '0;
      state         <= IDLE;
      mask          <= '0;
      shadow        <= '0;
      shadow_dp     <= '0;
      digit_q       <= '0;
      dp_q          <= '0;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      com_err_q     <= 1'b0;
    end else begin
      com_q     <= bus.fnd_com;
      data_q    <= bus.fnd_data;
      com_prev  <= com_q;
      data_prev <= data_q;

      if (changed)
        stab_cnt <= '0;
      else if (stab_cnt != CNT_SAT)
        stab_cnt <= stab_cnt + 8'd1;

      case (state)
        IDLE:    if (com_q != 4'hF) state <= SETTLE;
        SETTLE: begin
          if (changed)      state <= (com_q == 4'hF) ? IDLE : SETTLE;
          else if (capture) state <= HELD;
        end
        HELD:    if (changed) state <= (com_q == 4'hF) ? IDLE : SETTLE;
        default: state <= IDLE;
      endcase

      frame_valid_q <= 1'b0;
      if (wr_ok) begin
        shadow    <= shadow_nxt;
        shadow_dp <= dp_nxt;
        // The completing capture is folded into the committed frame on the same edge.
        if (next_mask == 4'hF) begin
          digit_q       <= shadow_nxt;
          dp_q          <= dp_nxt;
          frame_valid_q <= 1'b1;
          mask          <= '0;
        end else begin
          mask <= next_mask;
        end
      end

      seg_err_q <= seg_ev | (seg_err_q & ~bus.clr_err);
      com_err_q <= com_ev | (com_err_q & ~bus.clr_err);
    end
  end

  assign bus.digit0      = digit_q[0];
  assign bus.digit1      = digit_q[1];
  assign bus.digit2      = digit_q[2];
  assign bus.digit3      = digit_q[3];
  assign bus.dp_out      = dp_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.com_err     = com_err_q;

endmodule

// File: doc/fnd_scan_decoder.md
FND_SCAN_DECODER -- requirements
Module: fnd_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive clocks a com/data pair must hold before capture, legal 2..255.
REQ-002 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port fnd_com, input, 4: digit select, active-low; bit0 = rightmost digit.
REQ-005 SHALL have port fnd_data, input, 8: segments, active-low, {dp,g,f,e,d,c,b,a}.
REQ-006 SHALL have port clr_err, input, 1: synchronous clear of sticky error flags.
REQ-007 SHALL have port digit3..digit0, output, 4 each: last committed decoded digit values.
REQ-008 SHALL have port dp_out, output, 4: last committed decimal points, active-high, bit n = digit n.
REQ-009 SHALL have port frame_valid, output, 1: one-cycle pulse on each commit.
REQ-010 SHALL have port seg_err, output, 1: sticky flag, undecodable segment pattern captured.
REQ-011 SHALL have port com_err, output, 1: sticky flag, more than one fnd_com bit low for STABLE_CYCLES.

Function
REQ-012 SHALL register fnd_com and fnd_data in one input stage; all later logic uses the registered values.
REQ-013 SHALL hold a stability counter: cleared when registered {com,data} differs from its previous-cycle value, otherwise incremented, saturating at STABLE_CYCLES.
REQ-014 SHALL implement FSM states IDLE, SETTLE, HELD.
REQ-015 IDLE: registered fnd_com = 4'hF; no capture; on any other value go to SETTLE.
REQ-016 SETTLE: on the edge where counter reaches STABLE_CYCLES-1 with unchanged inputs, perform one capture and go to HELD; an input change returns to SETTLE with counter 0.
REQ-017 HELD: no further capture; an input change goes to SETTLE (or IDLE if com = 4'hF).
REQ-018 A capture with exactly one com bit low SHALL decode bits [6:0]: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 7F(blank)->F (hex).
REQ-019 A valid capture SHALL write the value and ~fnd_data[7] into the shadow slot of the selected digit and set that slot's bit in a 4-bit collected mask.
REQ-020 A capture with an undecodable pattern SHALL set seg_err, leave the shadow slot and mask unchanged.
REQ-021 A capture with two or more com bits low SHALL set com_err and write nothing.
REQ-022 Re-capture of a digit already in the mask SHALL overwrite its shadow slot (latest value wins).
REQ-023 When a capture makes mask = 4'hF, on that same edge SHALL copy all four shadow slots to digit0..3/dp_out, assert frame_valid for the next cycle only, clear mask to 0.
REQ-024 Outputs digit0..3/dp_out SHALL change only on commit, never partially.
REQ-025 clr_err SHALL clear seg_err/com_err; an error event on the same edge wins (flag stays 1).
REQ-026 Latency input change to capture SHALL be exactly STABLE_CYCLES+1 clock edges.

Reset
REQ-027 rst low SHALL immediately force: digit0..3 = 0, dp_out = 0, frame_valid = 0, seg_err = 0, com_err = 0, mask = 0, shadow = 0, counter = 0, FSM = IDLE, input register = {4'hF, 8'hFF}.
REQ-028 Reset asserted mid-frame SHALL discard partial frame; first commit after release requires four fresh captures.

Verification
REQ-029 Scan com E,D,B,7 with data C0,F9,A4,B0, 10 clocks each -> one frame_valid pulse after 4th capture; digit0..3 = 0,1,2,3; dp_out = 0.
REQ-030 Same scan with digit2 data 24 (dp on) and held 3 clocks only, STABLE_CYCLES = 4 -> no commit on that pass; next full pass commits digit2 = 2, dp_out = 4'b0100.
REQ-031 Data 0x55 on com E for 10 clocks -> seg_err = 1, mask unchanged; clr_err pulse -> seg_err = 0.
REQ-032 com = 4'hC for 10 clocks -> com_err = 1, no capture, outputs unchanged.
REQ-033 Scan digits 0,1 (values 5,6), reselect digit0 with value 9, then digits 2,3 -> commit digit0 = 9, digit1 = 6.
REQ-034 Assert rst after 3 of 4 digits captured, release, scan 4 new digits -> exactly one frame_valid, only new values visible.
